// File: rtl/controller_reduce_seq_pkg.sv
// Shared widths, stack command codes and sequencer state codes for the
// expression-evaluator reduction sequencer.
package controller_reduce_seq_pkg;

  localparam int CD_N = 16;
  localparam int CO_N = 4;
  localparam int SC_N = 2;

  localparam logic [CD_N-1:0] CD_0 = '0;

  localparam logic [SC_N-1:0] SC_NON = 2'd0;
  localparam logic [SC_N-1:0] SC_POP = 2'd1;
  localparam logic [SC_N-1:0] SC_PUS = 2'd2;

  localparam logic [CO_N-1:0] CO_ADD = 4'd0;
  localparam logic [CO_N-1:0] CO_SUB = 4'd1;
  localparam logic [CO_N-1:0] CO_AND = 4'd2;
  localparam logic [CO_N-1:0] CO_XOR = 4'd3;

  typedef enum logic [2:0] {
    CR_IDLE = 3'd0,
    CR_POPB = 3'd1,
    CR_POPA = 3'd2,
    CR_EXEC = 3'd3,
    CR_PUSH = 3'd4,
    CR_ERR  = 3'd5
  } cr_state_e;

  function automatic logic cr_is_pop(input cr_state_e s);
    return (s == CR_POPB) || (s == CR_POPA);
  endfunction

endpackage

// File: rtl/controller_reduce_seq.sv
// One reduction step: pop B (and A unless unary), hold operands for the ALU
// latency, push the result. Owns the shared stack bus only while busy.
module controller_reduce_seq
  import controller_reduce_seq_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            start,
  input  logic            unary,
  input  logic [CO_N-1:0] op,
  input  logic            flush,
  input  logic            dt_empty,
  inout  wire  [CD_N-1:0] dt_data,
  output logic [SC_N-1:0] dt_cmd,
  input  logic [CD_N-1:0] al_C,
  output logic [CD_N-1:0] al_A,
  output logic [CD_N-1:0] al_B,
  output logic [CO_N-1:0] al_op,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

  cr_state_e       r_state;
  cr_state_e       w_next;
  logic            r_unary;
  logic [CO_N-1:0] r_op;
  logic [CD_N-1:0] r_a;
  logic [CD_N-1:0] r_b;
  logic [CD_N-1:0] r_r;
  logic [3:0]      r_cnt;
  logic [SC_N-1:0] w_cmd;
  logic            w_accept;
  logic            w_last;

  assign w_accept = (r_state == CR_IDLE) && start && !flush;
  assign w_last   = (r_state == CR_EXEC) && (r_cnt == 4'd1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= CR_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // flush overrides every transition, including a start seen in IDLE
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = CR_IDLE;
    end else begin
      case (r_state)
        CR_IDLE: if (start) w_next = CR_POPB;
        CR_POPB: begin
          if (dt_empty)     w_next = CR_ERR;
          else if (r_unary) w_next = CR_EXEC;
          else              w_next = CR_POPA;
        end
        CR_POPA: w_next = dt_empty ? CR_ERR : CR_EXEC;
        CR_EXEC: if (r_cnt == 4'd1) w_next = CR_PUSH;
        CR_PUSH: w_next = CR_IDLE;
        CR_ERR:  w_next = CR_IDLE;
        default: w_next = CR_IDLE;
      endcase
    end
  end

  // only the pop command looks at dt_empty; everything else is pure state decode
  always_comb begin
    w_cmd = SC_NON;
    busy  = (r_state != CR_IDLE);
    done  = (r_state == CR_PUSH);
    err   = (r_state == CR_ERR);
    if (cr_is_pop(r_state) && !dt_empty) begin
      w_cmd = SC_POP;
    end else if (r_state == CR_PUSH) begin
      w_cmd = SC_PUS;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_unary <= 1'b0;
      r_op    <= '0;
      r_a     <= CD_0;
      r_b     <= CD_0;
      r_r     <= CD_0;
    end else begin
      if (w_accept) begin
        r_unary <= unary;
        r_op    <= op;
      end
      if (w_cmd == SC_POP) begin
        if (r_state == CR_POPB) begin
          r_b <= dt_data;
          if (r_unary) r_a <= CD_0;
        end else begin
          r_a <= dt_data;
        end
      end
      if (w_last) r_r <= al_C;
    end
  end

  // latency counter: loaded on EXEC entry, result sampled on the cycle it reads 1
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= 4'd0;
    end else if (w_next == CR_EXEC) begin
      r_cnt <= (r_state == CR_EXEC) ? r_cnt - 4'd1 : LAT_LOAD;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  assign dt_cmd  = w_cmd;
  assign dt_data = (w_cmd == SC_PUS) ? r_r : {CD_N{1'bz}};
  assign al_A    = r_a;
  assign al_B    = r_b;
  assign al_op   = r_op;

endmodule

// File: tb/tb_controller_reduce_seq.sv
// Bench for controller_reduce_seq: two instances (ALU_LAT 1 and 3) share the
// control inputs; each gets its own stack model, ALU model and schedule model.
module tb_controller_reduce_seq;
  import controller_reduce_seq_pkg::*;

  typedef struct {
    logic [SC_N-1:0] cmd;
    logic            busy;
    logic            done;
    logic            err;
    logic            ops;
    logic [CD_N-1:0] a;
    logic [CD_N-1:0] b;
    logic [CD_N-1:0] val;
    logic [CO_N-1:0] op;
  } ent_t;

  logic            Clock;
  logic            Reset;
  logic            start;
  logic            unary;
  logic [CO_N-1:0] op;
  logic            flush;
  logic            dt_empty [2];
  wire  [CD_N-1:0] dt_data0;
  wire  [CD_N-1:0] dt_data1;
  logic [SC_N-1:0] dt_cmd   [2];
  logic [CD_N-1:0] al_C     [2];
  logic [CD_N-1:0] al_A     [2];
  logic [CD_N-1:0] al_B     [2];
  logic [CO_N-1:0] al_op    [2];
  logic            busy     [2];
  logic            done     [2];
  logic            err      [2];

  logic            drv_en   [2];
  logic [CD_N-1:0] drv_val  [2];

  assign dt_data0 = drv_en[0] ? drv_val[0] : {CD_N{1'bz}};
  assign dt_data1 = drv_en[1] ? drv_val[1] : {CD_N{1'bz}};

  controller_reduce_seq #(.ALU_LAT(1)) u_dut_l1 (
    .Clock(Clock), .Reset(Reset), .start(start), .unary(unary), .op(op),
    .flush(flush), .dt_empty(dt_empty[0]), .dt_data(dt_data0), .dt_cmd(dt_cmd[0]),
    .al_C(al_C[0]), .al_A(al_A[0]), .al_B(al_B[0]), .al_op(al_op[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  controller_reduce_seq #(.ALU_LAT(3)) u_dut_l3 (
    .Clock(Clock), .Reset(Reset), .start(start), .unary(unary), .op(op),
    .flush(flush), .dt_empty(dt_empty[1]), .dt_data(dt_data1), .dt_cmd(dt_cmd[1]),
    .al_C(al_C[1]), .al_A(al_A[1]), .al_B(al_B[1]), .al_op(al_op[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int              n_chk = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              s_cyc = 0;
  bit              fill = 0;
  ent_t            sch [2][24];
  int              sh [2];
  int              sn [2];
  logic [CD_N-1:0] stk [2][64];
  int              depth [2];
  logic [SC_N-1:0] p_cmd [2];
  logic [CD_N-1:0] p_val [2];
  int              stab [2];
  logic [35:0]     prev_snap [2];
  int              obs_done [2];
  int              obs_err [2];
  int              n_done [2];
  int              pops [2];
  logic [CD_N-1:0] obs_push [2];
  logic [CD_N-1:0] obs_a [2];
  logic [CD_N-1:0] obs_b [2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [CD_N-1:0] dd(input int i);
    return (i == 0) ? dt_data0 : dt_data1;
  endfunction

  function automatic logic [CD_N-1:0] alu(input logic [CD_N-1:0] a, input logic [CD_N-1:0] b,
                                          input logic [CO_N-1:0] o);
    case (o)
      CO_ADD:  return a + b;
      CO_SUB:  return a - b;
      CO_AND:  return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic ent_t mk(input logic [SC_N-1:0] c, input logic bz, input logic d,
                              input logic e, input logic o);
    ent_t t;
    t.cmd = c; t.busy = bz; t.done = d; t.err = e; t.ops = o;
    t.a = '0; t.b = '0; t.val = '0; t.op = '0;
    return t;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [ALU_LAT=%0d] cyc=%0d got=%h want=%h", nm, lat(i), cyc, act, exp);
    end
  endtask

  task automatic put(input int i, input ent_t e);
    sch[i][sn[i]] = e;
    sn[i]++;
  endtask

  // Expected per-cycle outputs of a whole reduction, derived from the stack
  // contents at the accepting edge.
  task automatic build(input int i);
    int d;
    ent_t e;
    logic [CD_N-1:0] va, vb;
    d = depth[i];
    sh[i] = 0;
    sn[i] = 0;
    if (d == 0) begin
      put(i, mk(SC_NON, 1, 0, 0, 0));
      put(i, mk(SC_NON, 1, 0, 1, 0));
    end else if (!unary && d < 2) begin
      put(i, mk(SC_POP, 1, 0, 0, 0));
      put(i, mk(SC_NON, 1, 0, 0, 0));
      put(i, mk(SC_NON, 1, 0, 1, 0));
    end else begin
      vb = stk[i][d-1];
      va = unary ? CD_0 : stk[i][d-2];
      put(i, mk(SC_POP, 1, 0, 0, 0));
      if (!unary) put(i, mk(SC_POP, 1, 0, 0, 0));
      for (int k = 0; k < lat(i); k++) begin
        e = mk(SC_NON, 1, 0, 0, 1);
        e.a = va; e.b = vb; e.op = op;
        put(i, e);
      end
      e = mk(SC_PUS, 1, 1, 0, 1);
      e.a = va; e.b = vb; e.op = op; e.val = alu(va, vb, op);
      put(i, e);
    end
  endtask

  task automatic cycle();
    ent_t exp;
    logic [35:0] snap;
    @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      snap = {al_A[i], al_B[i], al_op[i]};
      if (snap !== prev_snap[i]) begin
        stab[i] = 0;
        prev_snap[i] = snap;
      end else begin
        stab[i]++;
      end
      al_C[i] = (stab[i] >= lat(i) - 1) ? alu(al_A[i], al_B[i], al_op[i]) : CD_N'($urandom);

      exp = (Reset && sn[i] > 0) ? sch[i][sh[i]] : mk(SC_NON, 0, 0, 0, 0);
      chk("dt_cmd", i, 32'(dt_cmd[i]), 32'(exp.cmd));
      chk("busy",   i, 32'(busy[i]),   32'(exp.busy));
      chk("done",   i, 32'(done[i]),   32'(exp.done));
      chk("err",    i, 32'(err[i]),    32'(exp.err));
      if (exp.cmd == SC_PUS) chk("push_data", i, 32'(dd(i)), 32'(exp.val));
      else                   chk("dt_data_z", i, 32'(dd(i)), 32'h0000zzzz);
      if (exp.ops) begin
        chk("al_A",  i, 32'(al_A[i]),  32'(exp.a));
        chk("al_B",  i, 32'(al_B[i]),  32'(exp.b));
        chk("al_op", i, 32'(al_op[i]), 32'(exp.op));
      end

      if (done[i] === 1'b1) begin
        n_done[i]++;
        if (obs_done[i] < 0) begin
          obs_done[i] = cyc - s_cyc + 1;
          obs_push[i] = dd(i);
          obs_a[i] = al_A[i];
          obs_b[i] = al_B[i];
        end
      end
      if (err[i] === 1'b1 && obs_err[i] < 0) obs_err[i] = cyc - s_cyc + 1;
      if (dt_cmd[i] == SC_POP) pops[i]++;

      p_cmd[i] = dt_cmd[i];
      p_val[i] = dd(i);
      if (dt_cmd[i] == SC_POP) begin
        drv_en[i] = 1'b1;
        drv_val[i] = (depth[i] > 0) ? stk[i][depth[i]-1] : 'x;
      end
    end
    @(posedge Clock);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (p_cmd[i] == SC_POP) begin
        if (depth[i] > 0) depth[i]--;
      end else if (p_cmd[i] == SC_PUS) begin
        stk[i][depth[i]] = p_val[i];
        if (depth[i] < 63) depth[i]++;
      end
      drv_en[i] = 1'b0;
      p_cmd[i] = SC_NON;

      if (!Reset) begin
        sn[i] = 0;
      end else if (sn[i] == 0) begin
        if (start && !flush) build(i);
      end else begin
        sh[i]++;
        sn[i]--;
        if (flush) sn[i] = 0;
      end

      if (fill && sn[i] == 0 && depth[i] < 6 && $urandom_range(0, 2) == 0) begin
        stk[i][depth[i]] = CD_N'($urandom);
        depth[i]++;
      end
      dt_empty[i] = (depth[i] == 0);
    end
  endtask

  task automatic load(input int n, input logic [CD_N-1:0] v0, input logic [CD_N-1:0] v1);
    for (int i = 0; i < 2; i++) begin
      stk[i][0] = v0;
      stk[i][1] = v1;
      depth[i] = n;
      dt_empty[i] = (n == 0);
    end
  endtask

  task automatic arm();
    s_cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      obs_done[i] = -1;
      obs_err[i] = -1;
      n_done[i] = 0;
      pops[i] = 0;
    end
  endtask

  task automatic run_op(input logic u, input logic [CO_N-1:0] o, input int ncyc);
    arm();
    start = 1'b1;
    unary = u;
    op = o;
    cycle();
    start = 1'b0;
    repeat (ncyc - 1) cycle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_cmd"},  i, 32'(dt_cmd[i]), 32'(SC_NON));
      chk({tag, "_busy"}, i, 32'(busy[i]), 32'd0);
      chk({tag, "_done"}, i, 32'(done[i]), 32'd0);
      chk({tag, "_err"},  i, 32'(err[i]), 32'd0);
      chk({tag, "_alA"},  i, 32'(al_A[i]), 32'd0);
      chk({tag, "_alB"},  i, 32'(al_B[i]), 32'd0);
      chk({tag, "_alop"}, i, 32'(al_op[i]), 32'd0);
      chk({tag, "_data"}, i, 32'(dd(i)), 32'h0000zzzz);
    end
  endtask

  initial begin
    Reset = 1'b0;
    start = 1'b0;
    unary = 1'b0;
    op = '0;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sh[i] = 0; sn[i] = 0; depth[i] = 0; dt_empty[i] = 1'b1;
      drv_en[i] = 1'b0; drv_val[i] = '0; p_cmd[i] = SC_NON; p_val[i] = '0;
      stab[i] = 0; prev_snap[i] = 'x; al_C[i] = '0;
    end
    arm();

    cycle();
    chk_reset_outputs("por");
    cycle();
    Reset = 1'b1;
    cycle();

    // [3,5] add -> 8
    load(2, 16'd3, 16'd5);
    run_op(1'b0, CO_ADD, 8);
    for (int i = 0; i < 2; i++) begin
      chk("bin_done_cycle", i, 32'(obs_done[i]), 32'(i == 0 ? 4 : 6));
      chk("bin_push", i, 32'(obs_push[i]), 32'd8);
      chk("bin_A", i, 32'(obs_a[i]), 32'd3);
      chk("bin_B", i, 32'(obs_b[i]), 32'd5);
      chk("bin_pops", i, 32'(pops[i]), 32'd2);
      chk("bin_depth", i, 32'(depth[i]), 32'd1);
      chk("bin_top", i, 32'(stk[i][0]), 32'd8);
    end

    // [7] unary negate -> -7
    load(1, 16'd7, 16'd0);
    run_op(1'b1, CO_SUB, 8);
    for (int i = 0; i < 2; i++) begin
      chk("un_done_cycle", i, 32'(obs_done[i]), 32'(i == 0 ? 3 : 5));
      chk("un_push", i, 32'(obs_push[i]), 32'h0000fff9);
      chk("un_A", i, 32'(obs_a[i]), 32'd0);
      chk("un_B", i, 32'(obs_b[i]), 32'd7);
      chk("un_pops", i, 32'(pops[i]), 32'd1);
    end

    // [4] binary -> underflow in POPA
    load(1, 16'd4, 16'd0);
    run_op(1'b0, CO_ADD, 6);
    for (int i = 0; i < 2; i++) begin
      chk("uf_err_cycle", i, 32'(obs_err[i]), 32'd3);
      chk("uf_no_done", i, 32'(n_done[i]), 32'd0);
      chk("uf_depth", i, 32'(depth[i]), 32'd0);
      chk("uf_pops", i, 32'(pops[i]), 32'd1);
    end

    // empty stack start
    load(0, 16'd0, 16'd0);
    run_op(1'b0, CO_ADD, 5);
    for (int i = 0; i < 2; i++) begin
      chk("empty_err_cycle", i, 32'(obs_err[i]), 32'd2);
      chk("empty_pops", i, 32'(pops[i]), 32'd0);
    end

    // flush during cycle 4 after start (EXEC #2 at ALU_LAT=3, PUSH at ALU_LAT=1)
    load(2, 16'd3, 16'd5);
    arm();
    start = 1'b1; unary = 1'b0; op = CO_ADD;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (4) cycle();
    for (int i = 0; i < 2; i++) begin
      chk("flush_done_cnt", i, 32'(n_done[i]), 32'(i == 0 ? 1 : 0));
      chk("flush_depth", i, 32'(depth[i]), 32'(i == 0 ? 1 : 0));
    end

    // start together with flush in IDLE
    load(2, 16'd1, 16'd2);
    start = 1'b1; flush = 1'b1;
    cycle();
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) chk("start_flush_idle", i, 32'(busy[i]), 32'd0);
    cycle();

    // reset asserted during POPA
    load(2, 16'd3, 16'd5);
    arm();
    start = 1'b1; op = CO_XOR;
    cycle();
    start = 1'b0;
    cycle();
    Reset = 1'b0;
    #1;
    chk_reset_outputs("rst_popa");
    cycle();
    Reset = 1'b1;
    cycle();
    for (int i = 0; i < 2; i++) chk("rst_popa_depth", i, 32'(depth[i]), 32'd1);

    // randomized traffic
    fill = 1;
    for (int k = 0; k < 700; k++) begin
      start = ($urandom_range(0, 3) == 0);
      unary = ($urandom_range(0, 2) == 0);
      op = CO_N'($urandom_range(0, 3));
      flush = ($urandom_range(0, 19) == 0);
      if (k == 350) begin
        Reset = 1'b0;
        cycle();
        Reset = 1'b1;
      end
      cycle();
    end
    start = 1'b0;
    flush = 1'b0;
    fill = 0;
    repeat (25) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/controller_reduce_seq.md
# controller_reduce_seq

Multi-cycle sequencer that performs one reduction step of the calculator's expression evaluator: pops operands from the data stack, presents them to the ALU, waits a fixed ALU latency and pushes the result back. It sits between the controller state machine (which requests a reduction via `start`) and the shared data-stack command/data bus, and owns that bus only while busy. Stack underflow is detected and reported instead of corrupting state.

## Interface
- `ALU_LAT`, default 1: ALU cycles from stable `al_A`/`al_B`/`al_op` to valid `al_C`; legal range 1..15.
- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one reduction; sampled only in IDLE.
- `unary`  in  1  sampled with `start`; 1 = single-operand op.
- `op`  in  `CO_N`  operator; latched with `start`.
- `flush`  in  1  synchronous abort; highest priority after reset.
- `dt_empty`  in  1  data stack empty, valid before the current edge's command.
- `dt_data`  inout  `CD_N`  stack data bus; driven by this block only when `dt_cmd == SC_PUS`, else `z`.
- `dt_cmd`  out  `SC_N`  stack command: `SC_NON`/`SC_POP`/`SC_PUS`.
- `al_C`  in  `CD_N`  ALU result.
- `al_A`, `al_B`  out  `CD_N`  registered operands.
- `al_op`  out  `CO_N`  registered operator.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  high for exactly the PUSH cycle.
- `err`  out  1  high for exactly the ERR cycle (underflow).

## Operation
- States: IDLE, POPB, POPA, EXEC, PUSH, ERR (encoding in shared include).
- IDLE: `dt_cmd = SC_NON`. `start` -> latch `op`, `unary`; go POPB.
- POPB: if `dt_empty` -> ERR, `dt_cmd = SC_NON`. Else `dt_cmd = SC_POP`, capture `dt_data` into B at edge; `unary` -> A := `CD_0`, go EXEC; else go POPA.
- POPA: if `dt_empty` -> ERR (B already consumed; not restored). Else `SC_POP`, capture A, go EXEC.
- EXEC: `SC_NON`; 4-bit counter loaded with `ALU_LAT` on entry, decrements each cycle; on the cycle it reads 1, capture `al_C` into R, go PUSH.
- PUSH: `dt_cmd = SC_PUS`, `dt_data = R`, `done = 1`; go IDLE.
- ERR: `SC_NON`, `err = 1`; go IDLE.
- `flush` in any state: next state IDLE, no further stack command issued; a command already asserted in the current cycle completes.
- `start` while busy ignored; no queueing.
- Stack semantics: on `SC_POP` the stack drives the top word on `dt_data` during that cycle; this block samples it at the closing edge.
- Widths: A, B, R are `CD_N`; no arithmetic here beyond the counter.

## Timing
- Reset (async, `Reset = 0`): state IDLE, `dt_cmd = SC_NON`, `dt_data = z`, A/B/R = `CD_0`, `al_op` = 0, counter 0, `busy`/`done`/`err` = 0. Reset deassertion mid-operation always resumes from IDLE.
- Binary latency: start edge -> POPB -> POPA -> EXEC×`ALU_LAT` -> PUSH: `done` in cycle 3 + `ALU_LAT` after the `start` edge; unary one cycle less.
- Outputs `dt_cmd`, `done`, `err`, `busy` are decoded from registered state (Moore), plus `dt_empty` gating in POPB/POPA (Mealy on `dt_cmd` only).
- `al_A`, `al_B`, `al_op` stable from EXEC entry through PUSH.
- Simultaneous `start` and `flush` in IDLE: stay IDLE.

## Structure
- State codes added to `CONT_INTERNAL.v` (`CR_*` macros); reuse `SC_*`, `CD_*`, `CO_*` from `STACK_INTERFACE.v`/`CPU_INTERNAL.v`.
- Single module; no sub-module needed (latency counter is inline).

## Test plan
- Binary: stack [3,5] (5 top), `op` add, `ALU_LAT=1`, model ALU -> two POP cycles, `al_A=3`, `al_B=5`, PUSH of 8, `done` 4 cycles after start.
- Unary: stack [7], `unary=1`, negate -> one POP, `al_A=0`, `al_B=7`, push `-7`, `done` at cycle 3.
- Underflow: stack [4], binary start -> POPB pops 4, POPA sees `dt_empty`, `err` one cycle, no PUSH, stack empty.
- Empty stack start -> `err` in cycle 2, `dt_cmd` never POP.
- `ALU_LAT=3`: `done` at cycle 6; flush in EXEC cycle 2 -> IDLE next cycle, no push.
- Reset asserted in POPA -> all outputs at reset values immediately; `dt_data` released to `z`.
